irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
- Machine-level interrupt controller sitting in front of the pipeline's exception unit.
- Collects N_SRC asynchronous external interrupt lines and latches them as pending.
- Arbitrates by programmable priority against a threshold and drives the single `interrupt` input of the trap logic.
- Holds the claimed source ID until software completes it, via a CSR-style config port or an `mret`.

Parameters:
- N_SRC, 4: number of external interrupt sources. IDs are 1..N_SRC; ID 0 means none.
- PRIO_W, 2: width of each priority field and of the threshold.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- irq_src  in  N_SRC  raw interrupt lines, asynchronous, rising-edge events
- cfg_we  in  1  config write strobe
- cfg_addr  in  4  config word address
- cfg_wdata  in  32  config write data
- cfg_rdata  out  32  config read data, combinational on cfg_addr
- trap_taken  in  1  exception unit accepted the interrupt trap this cycle (interrupt & MIE)
- mret  in  1  mret retiring; completes the current claim
- interrupt  out  1  registered interrupt request to the exception unit
- irq_id  out  8  ID currently requested or claimed; 0 if none

Behaviour:
- Reset (rst=0, async): state=IDLE; interrupt=0; irq_id=0; claim_id=0; pending=0; enable=0; threshold=0; all prio=0; synchronizers=0.
- Because every prio resets to 0 and must exceed threshold, no interrupt can fire until prio is programmed.
- Register map (word addresses):
  - 0x0 PENDING: read-only, bits[N_SRC-1:0].
  - 0x1 ENABLE: read/write.
  - 0x2 THRESHOLD: read/write, low PRIO_W bits.
  - 0x3 CLAIM/COMPLETE: read returns claim_id; a write with wdata==claim_id completes the claim.
  - 0x4+i PRIO[i]: read/write, for i < N_SRC.
  - Unmapped addresses read 0; writes to them are ignored.
  - Read data is zero-extended to 32 bits.
- Gateway, per source:
  - Two-flop synchronizer, then rising-edge detect.
  - A rise first sampled at edge 0 sets pending[i] after edge 2.
  - Level held high does not re-trigger.
- Arbitration, combinational:
  - A source is a candidate when pending & enable & (prio > threshold).
  - Winner is the highest prio; ties go to the lowest index.
  - win_id = index+1, or 0 if there is no candidate.
- FSM:
  - IDLE: if win_id≠0, go to REQ and set irq_id=win_id.
  - REQ:
    - interrupt=1, and irq_id tracks win_id every cycle, so a higher-priority arrival preempts before the claim.
    - If win_id becomes 0 (source disabled or threshold raised), go to IDLE with interrupt=0 and irq_id=0.
    - If trap_taken: go to SERVICE, claim_id=irq_id, clear pending[irq_id-1].
  - SERVICE:
    - interrupt=0; irq_id=claim_id.
    - New events still set pending but cannot request.
    - A complete write with a matching ID, or mret, takes the block to IDLE with claim_id=0.
    - A complete write with a non-matching ID is ignored.
- Latency: rise at edge 0 → pending after edge 2 → interrupt=1 after edge 3. After complete or mret, interrupt can re-assert after 2 edges (IDLE→REQ).
- Simultaneous events:
  - Pending clear at trap_taken and a new edge on the same source in the same cycle: set wins.
  - Complete and mret in the same cycle: a single completion.
  - trap_taken while in IDLE or SERVICE: ignored.
  - A config write to ENABLE or PRIO takes effect on the arbitration in the next cycle.

Optional Feature:
- Macro: IRQ_ARB_TIMER_EN.
- Defined:
  - Adds a 32-bit mtime counter (incrementing every cycle, wrapping at 2^32) at 0xC and mtimecmp at 0xD. Both are read/write; mtimecmp resets to 0xFFFFFFFF.
  - Adds timer source ID N_SRC+1, level-sensitive (candidate while mtime ≥ mtimecmp) with no pending latch.
  - Its priority is fixed at 2^PRIO_W−1 and it loses ties to external sources.
  - Gated by ENABLE bit N_SRC.
  - A software write to mtime wins over the increment.
- Undefined: 0xC and 0xD read 0 and ignore writes; ENABLE bit N_SRC is read-only 0.

Test Plan:
- Reset then raise irq_src[2] with prio[2]=0 → pending=0b0100, interrupt stays 0 indefinitely.
- Set prio[2]=2, threshold=1, enable=0xF; pulse irq_src[2] → interrupt=1 and irq_id=3 after edge 3; trap_taken → interrupt=0, read 0x3=3, pending[2]=0; write 0x3=3 → IDLE, claim_id=0.
- Pend src1 (prio1) and src3 (prio3), threshold 0 → irq_id=4 first. Complete with write 0x3=2 → ignored, claim_id stays 4. mret → IDLE, then irq_id=2.
- Equal prio=2 on src0 and src1, both pending → irq_id=1. In REQ, clear enable bit0 → irq_id switches to 2 with interrupt still 1.
- Assert rst=0 mid-SERVICE asynchronously → interrupt=0, irq_id=0, cfg_rdata at 0x1=0 immediately, without waiting for a clock edge.
- With IRQ_ARB_TIMER_EN: mtimecmp=mtime+10, enable bit N_SRC set → interrupt=1 and irq_id=N_SRC+1 once mtime ≥ mtimecmp; without the macro, read 0xD=0.

Source files
------------

// File: rtl/irq_arbiter_if.sv
// -----------------------------------------------------------------------------
// irq_arbiter_if
//   Bundles every non-clock, non-reset signal of irq_arbiter: the raw interrupt
//   lines, the CSR-style config port, and the exception-unit handshake.
//
//   Signals
//     irq_src    [N_SRC] raw interrupt lines (asynchronous, rising-edge events)
//     cfg_we             config write strobe
//     cfg_addr   [4]     config word address
//     cfg_wdata  [32]    config write data
//     cfg_rdata  [32]    config read data, combinational on cfg_addr
//     trap_taken         exception unit accepted the interrupt trap this cycle
//     mret               mret retiring; completes the current claim
//     interrupt          registered interrupt request to the exception unit
//     irq_id     [8]     ID currently requested or claimed; 0 if none
//
//   Modports
//     master : the CPU / system side (drives sources, config and handshake)
//     slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface irq_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0] irq_src;
  logic             cfg_we;
  logic [3:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic [31:0]      cfg_rdata;
  logic             trap_taken;
  logic             mret;
  logic             interrupt;
  logic [7:0]       irq_id;

  modport master (
    output irq_src, cfg_we, cfg_addr, cfg_wdata, trap_taken, mret,
    input  cfg_rdata, interrupt, irq_id
  );

  modport slave (
    input  irq_src, cfg_we, cfg_addr, cfg_wdata, trap_taken, mret,
    output cfg_rdata, interrupt, irq_id
  );
endinterface

// File: rtl/irq_arbiter.sv
// -----------------------------------------------------------------------------
// irq_arbiter
//   Machine-level interrupt controller in front of the exception unit.
//   External lines are synchronized, edge-detected and latched as pending.
//   Enabled pending sources whose priority exceeds the threshold compete; the
//   highest priority wins (lowest index on a tie). The winner is presented on
//   `interrupt`/`irq_id` until the trap is taken, then held as the claim until
//   software completes it (CLAIM/COMPLETE write of the matching ID, or mret).
//
//   Ports
//     clk  system clock
//     rst  asynchronous, active-low reset
//     bus  irq_arbiter_if.slave (sources, config port, trap handshake)
//
//   Register map (word addresses, read data zero-extended to 32 bits)
//     0x0       PENDING         read-only
//     0x1       ENABLE          read/write (bit N_SRC = timer enable, if built)
//     0x2       THRESHOLD       read/write, low PRIO_W bits
//     0x3       CLAIM/COMPLETE  read claim_id; write matching ID to complete
//     0x4+i     PRIO[i]         read/write, i < N_SRC
//     0xC/0xD   MTIME/MTIMECMP  only with the timer built in
//     others    read 0, writes ignored
//
//   Build option
//     IRQ_ARB_TIMER_EN : adds mtime/mtimecmp and timer source ID N_SRC+1,
//                        level-sensitive, fixed top priority, loses ties to
//                        external sources, gated by ENABLE bit N_SRC.
// -----------------------------------------------------------------------------
module irq_arbiter #(
  parameter int N_SRC  = 4,
  parameter int PRIO_W = 2
) (
  input logic          clk,
  input logic          rst,
  irq_arbiter_if.slave bus
);

  localparam logic [3:0] ADDR_PENDING   = 4'h0;
  localparam logic [3:0] ADDR_ENABLE    = 4'h1;
  localparam logic [3:0] ADDR_THRESHOLD = 4'h2;
  localparam logic [3:0] ADDR_CLAIM     = 4'h3;
  localparam int         ADDR_PRIO0     = 4;
`ifdef IRQ_ARB_TIMER_EN
  localparam logic [3:0]        ADDR_MTIME    = 4'hC;
  localparam logic [3:0]        ADDR_MTIMECMP = 4'hD;
  localparam logic [PRIO_W-1:0] TIMER_PRIO    = '1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [N_SRC-1:0]  sync1_q, sync1_d;
  logic [N_SRC-1:0]  sync2_q, sync2_d;
  logic [N_SRC-1:0]  prev_q, prev_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  enable_q, enable_d;
  logic [PRIO_W-1:0] threshold_q, threshold_d;
  logic [PRIO_W-1:0] prio_q [N_SRC];
  logic [PRIO_W-1:0] prio_d [N_SRC];
  logic              interrupt_q, interrupt_d;
  logic [7:0]        irq_id_q, irq_id_d;
  logic [7:0]        claim_id_q, claim_id_d;
`ifdef IRQ_ARB_TIMER_EN
  logic [31:0]       mtime_q, mtime_d;
  logic [31:0]       mtimecmp_q, mtimecmp_d;
  logic              timer_en_q, timer_en_d;
  logic              timer_cand;
`endif

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  cand;
  logic [N_SRC-1:0]  clear_mask;
  logic [PRIO_W-1:0] best_prio;
  logic [7:0]        win_id;
  logic              complete_wr;
  logic [31:0]       rdata;
  logic              unused_wdata;

  // Only some write-data bits land in registers, depending on the build.
  assign unused_wdata = ^bus.cfg_wdata;

  // Rising edge seen on the synchronized line; a held level yields one pulse.
  assign rise = sync2_q & ~prev_q;

  assign complete_wr = bus.cfg_we && (bus.cfg_addr == ADDR_CLAIM) &&
                       (bus.cfg_wdata == {24'd0, claim_id_q});

`ifdef IRQ_ARB_TIMER_EN
  assign timer_cand = timer_en_q && (mtime_q >= mtimecmp_q) &&
                      (TIMER_PRIO > threshold_q);
`endif

  // ---------------------------------------------------------------------------
  // Arbitration: strict '>' when replacing keeps the lowest index on ties,
  // and the timer (checked last) therefore loses ties to external sources.
  // ---------------------------------------------------------------------------
  always_comb begin
    best_prio = '0;
    win_id    = 8'd0;
    for (int i = 0; i < N_SRC; i++) begin
      cand[i] = pending_q[i] && enable_q[i] && (prio_q[i] > threshold_q);
      if (cand[i] && ((win_id == 8'd0) || (prio_q[i] > best_prio))) begin
        best_prio = prio_q[i];
        win_id    = 8'(i + 1);
      end
    end
`ifdef IRQ_ARB_TIMER_EN
    if (timer_cand && ((win_id == 8'd0) || (TIMER_PRIO > best_prio))) begin
      win_id = 8'(N_SRC + 1);
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: gateway, config registers, FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    sync1_d     = bus.irq_src;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    enable_d    = enable_q;
    threshold_d = threshold_q;
    prio_d      = prio_q;
    state_d     = state_q;
    interrupt_d = interrupt_q;
    irq_id_d    = irq_id_q;
    claim_id_d  = claim_id_q;
    clear_mask  = '0;
`ifdef IRQ_ARB_TIMER_EN
    timer_en_d  = timer_en_q;
    mtime_d     = mtime_q + 32'd1;
    mtimecmp_d  = mtimecmp_q;
`endif

    // Config writes; PENDING and CLAIM are not plain storage.
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        ADDR_ENABLE: begin
          enable_d = bus.cfg_wdata[N_SRC-1:0];
`ifdef IRQ_ARB_TIMER_EN
          timer_en_d = bus.cfg_wdata[N_SRC];
`endif
        end
        ADDR_THRESHOLD: threshold_d = bus.cfg_wdata[PRIO_W-1:0];
`ifdef IRQ_ARB_TIMER_EN
        // A software write to mtime overrides this cycle's increment.
        ADDR_MTIME:    mtime_d    = bus.cfg_wdata;
        ADDR_MTIMECMP: mtimecmp_d = bus.cfg_wdata;
`endif
        default: begin
          for (int i = 0; i < N_SRC; i++) begin
            if (bus.cfg_addr == 4'(ADDR_PRIO0 + i)) begin
              prio_d[i] = bus.cfg_wdata[PRIO_W-1:0];
            end
          end
        end
      endcase
    end

    case (state_q)
      IDLE: begin
        interrupt_d = 1'b0;
        irq_id_d    = 8'd0;
        if (win_id != 8'd0) begin
          state_d     = REQ;
          interrupt_d = 1'b1;
          irq_id_d    = win_id;
        end
      end

      REQ: begin
        // The trap was accepted for the ID on the wire this cycle, so it
        // takes precedence over the winner disappearing at the same time.
        if (bus.trap_taken) begin
          state_d     = SERVICE;
          interrupt_d = 1'b0;
          claim_id_d  = irq_id_q;
          irq_id_d    = irq_id_q;
          for (int i = 0; i < N_SRC; i++) begin
            clear_mask[i] = (irq_id_q == 8'(i + 1));
          end
        end else if (win_id == 8'd0) begin
          state_d     = IDLE;
          interrupt_d = 1'b0;
          irq_id_d    = 8'd0;
        end else begin
          interrupt_d = 1'b1;
          irq_id_d    = win_id;
        end
      end

      SERVICE: begin
        interrupt_d = 1'b0;
        irq_id_d    = claim_id_q;
        // Complete and mret together still form a single completion.
        if (complete_wr || bus.mret) begin
          state_d    = IDLE;
          claim_id_d = 8'd0;
          irq_id_d   = 8'd0;
        end
      end

      default: begin
        state_d     = IDLE;
        interrupt_d = 1'b0;
        irq_id_d    = 8'd0;
        claim_id_d  = 8'd0;
      end
    endcase

    // A new edge in the same cycle as the claim clear keeps the source pending.
    pending_d = (pending_q & ~clear_mask) | rise;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      threshold_q <= '0;
      // NOTE: the priority array is a handful of software-visible flops, not
      // a RAM, so it is reset like any other register.
      for (int i = 0; i < N_SRC; i++) prio_q[i] <= '0;
      interrupt_q <= 1'b0;
      irq_id_q    <= 8'd0;
      claim_id_q  <= 8'd0;
`ifdef IRQ_ARB_TIMER_EN
      mtime_q     <= 32'd0;
      mtimecmp_q  <= 32'hFFFF_FFFF;
      timer_en_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      threshold_q <= threshold_d;
      prio_q      <= prio_d;
      interrupt_q <= interrupt_d;
      irq_id_q    <= irq_id_d;
      claim_id_q  <= claim_id_d;
`ifdef IRQ_ARB_TIMER_EN
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_en_q  <= timer_en_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: combinational on cfg_addr, zero-extended
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (bus.cfg_addr)
      ADDR_PENDING: rdata[N_SRC-1:0] = pending_q;
      ADDR_ENABLE: begin
        rdata[N_SRC-1:0] = enable_q;
`ifdef IRQ_ARB_TIMER_EN
        rdata[N_SRC] = timer_en_q;
`endif
      end
      ADDR_THRESHOLD: rdata[PRIO_W-1:0] = threshold_q;
      ADDR_CLAIM:     rdata[7:0]        = claim_id_q;
`ifdef IRQ_ARB_TIMER_EN
      ADDR_MTIME:     rdata = mtime_q;
      ADDR_MTIMECMP:  rdata = mtimecmp_q;
`endif
      default: begin
        for (int i = 0; i < N_SRC; i++) begin
          if (bus.cfg_addr == 4'(ADDR_PRIO0 + i)) begin
            rdata[PRIO_W-1:0] = prio_q[i];
          end
        end
      end
    endcase
  end

  assign bus.cfg_rdata = rdata;
  assign bus.interrupt = interrupt_q;
  assign bus.irq_id    = irq_id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_irq_arbiter
//   Directed bench for irq_arbiter. Each expected value is pushed onto a
//   scoreboard queue just before the DUT is sampled; check() pops it and
//   compares with an immediate assertion. Inputs change and outputs are
//   sampled 2 ns after the rising edge (20 ns period).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_irq_arbiter;
  localparam int N_SRC  = 4;
  localparam int PRIO_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  irq_arbiter_if #(.N_SRC(N_SRC)) bus ();

  irq_arbiter #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed=0x%0h expected=<none>", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.val) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we    = 1'b0;
    bus.cfg_wdata = '0;
  endtask

  task automatic check_rd(input string tag, input logic [3:0] addr,
                          input logic [31:0] exp);
    expect_val(tag, exp);
    bus.cfg_addr = addr;
    #1;
    check(bus.cfg_rdata);
  endtask

  task automatic check_out(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    expect_val(tag, exp);
    check(obs);
  endtask

  task automatic reset_pulse();
    bus.irq_src    = '0;
    bus.trap_taken = 1'b0;
    bus.mret       = 1'b0;
    bus.cfg_we     = 1'b0;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    bus.irq_src    = '0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_wdata  = '0;
    bus.trap_taken = 1'b0;
    bus.mret       = 1'b0;
    rst = 1'b0;
    #3;

    // Reset state
    check_out("rst_interrupt", 32'(bus.interrupt), 0);
    check_out("rst_irq_id", 32'(bus.irq_id), 0);
    check_rd("rst_pending", 4'h0, 0);
    check_rd("rst_enable", 4'h1, 0);
    check_rd("rst_threshold", 4'h2, 0);
    check_rd("rst_claim", 4'h3, 0);
    check_rd("rst_prio0", 4'h4, 0);
    check_rd("unmapped_8", 4'h8, 0);
    rst = 1'b1;
    tick();

    // Priority 0 never beats threshold 0: pending but silent
    bus.irq_src = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_out("prio0_silent", 32'(bus.interrupt), 0);
    end
    check_rd("prio0_pending", 4'h0, 32'h4);
    reset_pulse();

    // Basic request / claim / complete, latency from the rising edge
    cfg_write(4'h6, 2);
    cfg_write(4'h2, 1);
    cfg_write(4'h1, 32'hF);
    check_rd("prio2_rb", 4'h6, 2);
    bus.irq_src = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("latency_int_low", 32'(bus.interrupt), 0);
    end
    check_rd("pending_after_e2", 4'h0, 32'h4);
    tick();
    check_out("e3_interrupt", 32'(bus.interrupt), 1);
    check_out("e3_irq_id", 32'(bus.irq_id), 3);
    bus.trap_taken = 1'b1;
    tick();
    bus.trap_taken = 1'b0;
    check_out("svc_interrupt", 32'(bus.interrupt), 0);
    check_out("svc_irq_id", 32'(bus.irq_id), 3);
    check_rd("svc_claim", 4'h3, 3);
    check_rd("svc_pending_clr", 4'h0, 0);
    cfg_write(4'h3, 3);
    check_rd("cmpl_claim", 4'h3, 0);
    check_out("cmpl_irq_id", 32'(bus.irq_id), 0);
    repeat (4) tick();
    check_out("level_no_retrig", 32'(bus.interrupt), 0);
    bus.trap_taken = 1'b1;
    tick();
    bus.trap_taken = 1'b0;
    check_rd("idle_trap_ignored", 4'h3, 0);
    check_out("idle_trap_irq_id", 32'(bus.irq_id), 0);
    bus.irq_src = '0;

    // Priority order, wrong-ID complete, mret, set-wins-over-clear
    cfg_write(4'h2, 0);
    cfg_write(4'h5, 1);
    cfg_write(4'h7, 3);
    bus.irq_src = 4'b1010;
    repeat (4) tick();
    check_out("prio_irq_id", 32'(bus.irq_id), 4);
    check_out("prio_interrupt", 32'(bus.interrupt), 1);
    bus.trap_taken = 1'b1;
    tick();
    bus.trap_taken = 1'b0;
    bus.irq_src = '0;
    cfg_write(4'h3, 2);
    check_rd("bad_cmpl_claim", 4'h3, 4);
    check_out("bad_cmpl_irq_id", 32'(bus.irq_id), 4);
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    check_out("mret_irq_id", 32'(bus.irq_id), 0);
    check_rd("mret_claim", 4'h3, 0);
    tick();
    check_out("rearm_interrupt", 32'(bus.interrupt), 1);
    check_out("rearm_irq_id", 32'(bus.irq_id), 2);
    bus.irq_src = 4'b0010;
    tick();
    tick();
    check_out("req_hold_irq_id", 32'(bus.irq_id), 2);
    bus.trap_taken = 1'b1;
    tick();
    bus.trap_taken = 1'b0;
    check_rd("set_wins_claim", 4'h3, 2);
    check_rd("set_wins_pending", 4'h0, 32'h2);
    bus.irq_src = '0;
    bus.mret = 1'b1;
    cfg_write(4'h3, 2);
    bus.mret = 1'b0;
    check_rd("dual_cmpl_claim", 4'h3, 0);
    check_out("dual_cmpl_int", 32'(bus.interrupt), 0);
    tick();
    check_out("reassert_2edges", 32'(bus.interrupt), 1);
    check_out("reassert_irq_id", 32'(bus.irq_id), 2);
    bus.trap_taken = 1'b1;
    tick();
    bus.trap_taken = 1'b0;
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    tick();
    check_out("drained_int", 32'(bus.interrupt), 0);
    check_rd("drained_pending", 4'h0, 0);

    // Tie goes to lower index; disabling it mid-REQ preempts
    reset_pulse();
    cfg_write(4'h4, 2);
    cfg_write(4'h5, 2);
    cfg_write(4'h1, 32'hF);
    bus.irq_src = 4'b0011;
    repeat (4) tick();
    check_out("tie_irq_id", 32'(bus.irq_id), 1);
    cfg_write(4'h1, 32'hE);
    check_out("en_write_lag", 32'(bus.irq_id), 1);
    tick();
    check_out("preempt_irq_id", 32'(bus.irq_id), 2);
    check_out("preempt_int", 32'(bus.interrupt), 1);
    bus.trap_taken = 1'b1;
    tick();
    bus.trap_taken = 1'b0;
    check_rd("tie_claim", 4'h3, 2);

    // Asynchronous reset in SERVICE, observed before any clock edge
    rst = 1'b0;
    #3;
    check_out("async_rst_int", 32'(bus.interrupt), 0);
    check_out("async_rst_irq_id", 32'(bus.irq_id), 0);
    check_rd("async_rst_enable", 4'h1, 0);
    check_rd("async_rst_claim", 4'h3, 0);
    rst = 1'b1;
    bus.irq_src = '0;
    tick();

`ifdef IRQ_ARB_TIMER_EN
    // Timer source: fires once mtime reaches mtimecmp
    check_rd("mtimecmp_rst", 4'hD, 32'hFFFF_FFFF);
    cfg_write(4'hC, 0);
    cfg_write(4'hD, 10);
    check_rd("mtimecmp_rb", 4'hD, 10);
    cfg_write(4'h1, 32'(1) << N_SRC);
    check_rd("timer_en_rb", 4'h1, 32'(1) << N_SRC);
    repeat (5) tick();
    check_out("timer_early", 32'(bus.interrupt), 0);
    for (int k = 0; k < 20 && !bus.interrupt; k++) tick();
    check_out("timer_int", 32'(bus.interrupt), 1);
    check_out("timer_irq_id", 32'(bus.irq_id), N_SRC + 1);
`else
    // Without the timer, its addresses and enable bit are inert
    cfg_write(4'hD, 5);
    cfg_write(4'hC, 7);
    check_rd("no_timer_mtimecmp", 4'hD, 0);
    check_rd("no_timer_mtime", 4'hC, 0);
    cfg_write(4'h1, 32'h1F);
    check_rd("no_timer_en_bit", 4'h1, 32'hF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
